// File: rtl/alu_sequencer_if.sv
// Request/response handshake between the CPU-side issue logic and alu_sequencer.
// master = issuing side, slave = the sequencer.
interface alu_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic        resp_zr;
  logic        resp_ng;
  logic        busy;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_zr, resp_ng, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data, resp_zr, resp_ng, busy
  );
endinterface

// File: rtl/alu_sequencer.sv
// Owns the shared Hack ALU: maps opcodes onto its control word, runs single-cycle
// ops in one pass and a 16-iteration shift-add multiply, then holds the result.
module alu_sequencer (
  input  logic                clk,
  input  logic                rst_n,
  alu_sequencer_if.slave      bus,
  output logic [15:0]         alu_x,
  output logic [15:0]         alu_y,
  output logic                alu_zx,
  output logic                alu_nx,
  output logic                alu_zy,
  output logic                alu_ny,
  output logic                alu_f,
  output logic                alu_no,
  input  logic [15:0]         alu_out,
  input  logic                alu_zr,
  input  logic                alu_ng
);
  localparam int DATA_W = 16;

  localparam logic [5:0] CW_ZERO = 6'b101010;
  localparam logic [5:0] CW_X    = 6'b001100;
  localparam logic [5:0] CW_ADD  = 6'b000010;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  state_t              state;
  logic [3:0]          op_r;
  logic [DATA_W-1:0]   a_r;
  logic [DATA_W-1:0]   b_r;
  logic [DATA_W-1:0]   acc;
  logic [DATA_W-1:0]   mcand;
  logic [DATA_W-1:0]   mplier;
  logic [3:0]          cnt;
  logic [DATA_W-1:0]   resp_data_r;
  logic                resp_zr_r;
  logic                resp_ng_r;
  logic                resp_valid_r;
  logic                req_ready_r;
  logic                busy_r;
  logic [5:0]          ctrl;

  function automatic logic [5:0] op_ctrl(input logic [3:0] op);
    case (op)
      4'd0:    op_ctrl = 6'b101010;
      4'd1:    op_ctrl = 6'b111111;
      4'd2:    op_ctrl = 6'b111010;
      4'd3:    op_ctrl = 6'b001100;
      4'd4:    op_ctrl = 6'b110000;
      4'd5:    op_ctrl = 6'b001101;
      4'd6:    op_ctrl = 6'b001111;
      4'd7:    op_ctrl = 6'b011111;
      4'd8:    op_ctrl = 6'b001110;
      4'd9:    op_ctrl = 6'b000010;
      4'd10:   op_ctrl = 6'b010011;
      4'd11:   op_ctrl = 6'b000111;
      4'd12:   op_ctrl = 6'b000000;
      4'd13:   op_ctrl = 6'b010101;
      4'd15:   op_ctrl = 6'b000010;
      default: op_ctrl = CW_ZERO;
    endcase
  endfunction

  // ALU drive follows the registered state; IDLE/DONE park it on the ZERO word.
  always_comb begin
    alu_x = '0;
    alu_y = '0;
    ctrl  = CW_ZERO;
    case (state)
      EXEC: begin
        alu_x = a_r;
        alu_y = (op_r == 4'd15) ? a_r : b_r;
        ctrl  = op_ctrl(op_r);
      end
      MUL: begin
        alu_x = acc;
        alu_y = mcand;
        ctrl  = mplier[0] ? CW_ADD : CW_X;
      end
      default: ;
    endcase
  end

  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ctrl;

  assign bus.req_ready  = req_ready_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_data  = resp_data_r;
  assign bus.resp_zr    = resp_zr_r;
  assign bus.resp_ng    = resp_ng_r;
  assign bus.busy       = busy_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_r         <= '0;
      a_r          <= '0;
      b_r          <= '0;
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      cnt          <= '0;
      resp_data_r  <= '0;
      resp_zr_r    <= 1'b0;
      resp_ng_r    <= 1'b0;
      resp_valid_r <= 1'b0;
      req_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_r        <= bus.req_op;
            a_r         <= bus.req_a;
            b_r         <= bus.req_b;
            acc         <= '0;
            mcand       <= bus.req_a;
            mplier      <= bus.req_b;
            cnt         <= '0;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            state       <= (bus.req_op == 4'd14) ? MUL : EXEC;
          end
        end
        EXEC: begin
          resp_data_r  <= alu_out;
          resp_zr_r    <= alu_zr;
          resp_ng_r    <= alu_ng;
          resp_valid_r <= 1'b1;
          state        <= DONE;
        end
        MUL: begin
          acc    <= alu_out;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 4'd1;
          // Fixed 16 iterations; the last partial sum is the product.
          if (cnt == 4'd15) begin
            resp_data_r  <= alu_out;
            resp_zr_r    <= alu_zr;
            resp_ng_r    <= alu_ng;
            resp_valid_r <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          if (bus.resp_ready) begin
            resp_valid_r <= 1'b0;
            req_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
